// File: rtl/memory_read_arbiter.sv
// Round-robin arbiter sharing one memory read engine among N_PORTS requesters.
// Each port owns a one-deep request slot; a cont=1 transfer locks the engine to its port.
module memory_read_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_PORTS*LEN_WIDTH-1:0]    req_len,
    input  logic [N_PORTS-1:0]              req_start,
    input  logic [N_PORTS-1:0]              req_cont,
    output logic [N_PORTS-1:0]              req_busy,
    output logic [N_PORTS-1:0]              req_done,
    output logic [N_PORTS-1:0]              req_error,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [LEN_WIDTH-1:0]            mem_len,
    output logic                            mem_start,
    output logic                            mem_cont,
    input  logic                            mem_busy,
    input  logic                            mem_done,
    input  logic                            mem_error
);
    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state_q, state_d;

    logic [N_PORTS-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [N_PORTS-1:0][LEN_WIDTH-1:0]  len_q, len_d;
    logic [N_PORTS-1:0]                 cont_q, cont_d;
    logic [N_PORTS-1:0]                 pending_q, pending_d;
    logic [GW-1:0]                      grant_q, grant_d;
    logic [GW-1:0]                      last_grant_q, last_grant_d;
    logic [GW-1:0]                      lock_port_q, lock_port_d;
    logic                               lock_valid_q, lock_valid_d;
    logic [ADDR_WIDTH-1:0]              mem_addr_q, mem_addr_d;
    logic [LEN_WIDTH-1:0]               mem_len_q, mem_len_d;
    logic                               mem_start_q, mem_start_d;
    logic                               mem_cont_q, mem_cont_d;
    logic [N_PORTS-1:0]                 req_done_q, req_done_d;
    logic [N_PORTS-1:0]                 req_error_q, req_error_d;

    logic [N_PORTS-1:0] eligible;
    logic               found;
    logic [GW-1:0]      pick;
    logic [GW-1:0]      cand;
    int unsigned        scan_idx;

    // While locked only the lock owner may win; scan starts just after the last grant.
    always_comb begin
        eligible = pending_q;
        if (lock_valid_q) begin
            eligible              = '0;
            eligible[lock_port_q] = pending_q[lock_port_q];
        end
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            scan_idx = (32'(last_grant_q) + k + 1) % N_PORTS;
            cand     = GW'(scan_idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found)     state_d = ISSUE;
            ISSUE:   if (!mem_busy) state_d = WAIT;
            WAIT:    if (mem_done)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        len_d        = len_q;
        cont_d       = cont_q;
        pending_d    = pending_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lock_port_d  = lock_port_q;
        lock_valid_d = lock_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_len_d    = mem_len_q;
        mem_start_d  = mem_start_q;
        mem_cont_d   = mem_cont_q;
        req_done_d   = '0;
        req_error_d  = '0;

        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (req_start[i] && !pending_q[i]) begin
                addr_d[i]    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                len_d[i]     = req_len[i*LEN_WIDTH +: LEN_WIDTH];
                cont_d[i]    = req_cont[i];
                pending_d[i] = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    mem_addr_d   = addr_q[pick];
                    mem_len_d    = len_q[pick];
                    mem_cont_d   = cont_q[pick];
                    mem_start_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (!mem_busy) mem_start_d = 1'b0;
            end
            WAIT: begin
                if (mem_done) begin
                    req_done_d[grant_q]  = 1'b1;
                    req_error_d[grant_q] = mem_error;
                    pending_d[grant_q]   = 1'b0;
                    if (mem_error) begin
                        lock_valid_d = 1'b0;
                    end else if (cont_q[grant_q]) begin
                        lock_valid_d = 1'b1;
                        lock_port_d  = grant_q;
                    end else if (lock_port_q == grant_q) begin
                        lock_valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q       <= '0;
            len_q        <= '0;
            cont_q       <= '0;
            pending_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(N_PORTS - 1);
            lock_port_q  <= '0;
            lock_valid_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_len_q    <= '0;
            mem_start_q  <= 1'b0;
            mem_cont_q   <= 1'b0;
            req_done_q   <= '0;
            req_error_q  <= '0;
        end else begin
            addr_q       <= addr_d;
            len_q        <= len_d;
            cont_q       <= cont_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lock_port_q  <= lock_port_d;
            lock_valid_q <= lock_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_len_q    <= mem_len_d;
            mem_start_q  <= mem_start_d;
            mem_cont_q   <= mem_cont_d;
            req_done_q   <= req_done_d;
            req_error_q  <= req_error_d;
        end
    end

    assign req_busy  = pending_q;
    assign req_done  = req_done_q;
    assign req_error = req_error_q;
    assign mem_addr  = mem_addr_q;
    assign mem_len   = mem_len_q;
    assign mem_start = mem_start_q;
    assign mem_cont  = mem_cont_q;

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Bench for memory_read_arbiter: engine model plus issue/done scoreboards,
// a table of arbitration rounds and hand-written lock, stall and reset sequences.
module tb_memory_read_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int LW = 16;

    logic              clock;
    logic              resetn;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_len;
    logic [N-1:0]      req_start;
    logic [N-1:0]      req_cont;
    logic [N-1:0]      req_busy;
    logic [N-1:0]      req_done;
    logic [N-1:0]      req_error;
    logic [AW-1:0]     mem_addr;
    logic [LW-1:0]     mem_len;
    logic              mem_start;
    logic              mem_cont;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_error;

    memory_read_arbiter #(
        .N_PORTS   (N),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req_addr (req_addr),
        .req_len  (req_len),
        .req_start(req_start),
        .req_cont (req_cont),
        .req_busy (req_busy),
        .req_done (req_done),
        .req_error(req_error),
        .mem_addr (mem_addr),
        .mem_len  (mem_len),
        .mem_start(mem_start),
        .mem_cont (mem_cont),
        .mem_busy (mem_busy),
        .mem_done (mem_done),
        .mem_error(mem_error)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic          cont;
        logic          err;
        int            port;
    } xfer_t;

    typedef struct {
        logic [1:0]         start;
        logic [1:0][AW-1:0] addr;
        logic [1:0][LW-1:0] len;
        logic [1:0]         cont;
        logic [1:0]         err;
        int                 first;
    } row_t;

    xfer_t exp_issue[$];
    xfer_t exp_done[$];
    xfer_t eng_x;

    int errors = 0;
    int checks = 0;
    int eng_cnt = 0;
    int eng_lat = 8;
    int eng_busy_left = 0;
    logic eng_err = 1'b0;
    bit eng_drop = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic c);
        req_addr[p*AW +: AW] = a;
        req_len[p*LW +: LW]  = l;
        req_cont[p]          = c;
        req_start[p]         = 1'b1;
    endtask

    task automatic push_issue(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l,
                              input logic c, input logic e);
        xfer_t x;
        x.addr = a;
        x.len  = l;
        x.cont = c;
        x.err  = e;
        x.port = p;
        exp_issue.push_back(x);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n = 0;
        while ((exp_issue.size() != 0 || exp_done.size() != 0 || eng_cnt != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk(name, 64'(n < maxc), 64'd1);
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(req_busy), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_error", 64'(req_error), 64'd0);
        chk("rst_mem_start", 64'(mem_start), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_len", 64'(mem_len), 64'd0);
        chk("rst_mem_cont", 64'(mem_cont), 64'd0);
        resetn = 1'b1;
    endtask

    function automatic row_t mkrow(input logic [1:0] st, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                   input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                                   input logic c0, input logic c1, input logic e0, input logic e1,
                                   input int first);
        row_t r;
        r.start = st;
        r.addr  = {a1, a0};
        r.len   = {l1, l0};
        r.cont  = {c1, c0};
        r.err   = {e1, e0};
        r.first = first;
        return r;
    endfunction

    // Engine model and done monitor, both acting on the falling edge.
    initial begin
        xfer_t ex;
        mem_busy  = 1'b0;
        mem_done  = 1'b0;
        mem_error = 1'b0;
        forever begin
            @(negedge clock);
            if (req_done != '0) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 64'(req_done), 64'd0);
                end else begin
                    ex = exp_done.pop_front();
                    chk("done_port", 64'(req_done), 64'(1) << ex.port);
                    chk("done_error", 64'(req_error), ex.err ? (64'(1) << ex.port) : 64'd0);
                end
            end else if (req_error != '0) begin
                chk("error_without_done", 64'(req_error), 64'd0);
            end
            mem_done  = 1'b0;
            mem_error = 1'b0;
            mem_busy  = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    mem_done  = 1'b1;
                    mem_error = eng_err;
                    if (!eng_drop) exp_done.push_back(eng_x);
                end
            end else if (mem_start) begin
                if (exp_issue.size() == 0) begin
                    chk("unexpected_issue", 64'(mem_start), 64'd0);
                end else begin
                    ex = exp_issue[0];
                    chk("issue_addr", 64'(mem_addr), 64'(ex.addr));
                    chk("issue_len", 64'(mem_len), 64'(ex.len));
                    chk("issue_cont", 64'(mem_cont), 64'(ex.cont));
                    if (eng_busy_left > 0) begin
                        mem_busy = 1'b1;
                        eng_busy_left--;
                    end else begin
                        eng_x   = exp_issue.pop_front();
                        eng_err = eng_x.err;
                        eng_cnt = eng_lat;
                    end
                end
            end
        end
    end

    initial begin
        row_t rows[9];
        int   order[2];
        int   starts;

        rows[0] = mkrow(2'b11, 32'h0001_0000, 32'h0002_0000, 16'd16, 16'd32, 0, 0, 0, 0, 0);
        rows[1] = mkrow(2'b11, 32'h0001_0040, 32'h0002_0040, 16'd17, 16'd33, 0, 0, 0, 0, 0);
        rows[2] = mkrow(2'b11, 32'h0001_0080, 32'h0002_0080, 16'd18, 16'd34, 0, 0, 0, 0, 0);
        rows[3] = mkrow(2'b11, 32'h0001_00C0, 32'h0002_00C0, 16'd19, 16'd35, 0, 0, 0, 0, 0);
        rows[4] = mkrow(2'b10, 32'h0,         32'h0007_0000, 16'd0,  16'd8,  0, 0, 0, 1, 1);
        rows[5] = mkrow(2'b01, 32'h0008_0000, 32'h0,         16'd4,  16'd0,  1, 0, 0, 0, 0);
        rows[6] = mkrow(2'b11, 32'h0009_0000, 32'h000A_0000, 16'd5,  16'd6,  0, 0, 0, 0, 0);
        rows[7] = mkrow(2'b01, 32'h000B_0000, 32'h0,         16'd7,  16'd0,  0, 0, 1, 0, 0);
        rows[8] = mkrow(2'b11, 32'h000C_0000, 32'h000D_0000, 16'd9,  16'd10, 0, 0, 0, 0, 1);

        resetn    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_start = '0;
        req_cont  = '0;
        tick();
        reset_dut();

        // Single request: latency and busy window, cycle by cycle.
        drive_req(0, 32'h1000, 16'd64, 1'b0);
        push_issue(0, 32'h1000, 16'd64, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) req_start = '0;
            chk($sformatf("t1_busy_c%0d", c), 64'(req_busy[0]), 64'((c >= 1) && (c <= 10)));
            chk($sformatf("t1_start_c%0d", c), 64'(mem_start), 64'(c == 2));
            chk($sformatf("t1_done_c%0d", c), 64'(req_done[0]), 64'(c == 11));
            if (c == 2) chk("t1_addr", 64'(mem_addr), 64'h1000);
        end
        wait_drain("t1_drain", 50);

        reset_dut();

        // Arbitration rounds from the table.
        for (int r = 0; r < 9; r++) begin
            order[0] = rows[r].first;
            order[1] = 1 - rows[r].first;
            for (int k = 0; k < 2; k++) begin
                if (rows[r].start[order[k]])
                    push_issue(order[k], rows[r].addr[order[k]], rows[r].len[order[k]],
                               rows[r].cont[order[k]], rows[r].err[order[k]]);
            end
            for (int p = 0; p < 2; p++) begin
                if (rows[r].start[p])
                    drive_req(p, rows[r].addr[p], rows[r].len[p], rows[r].cont[p]);
            end
            tick();
            req_start = '0;
            wait_drain($sformatf("row%0d_drain", r), 200);
        end

        // Engine stalls for 5 cycles: mem_start held 6 cycles, one transfer.
        eng_busy_left = 5;
        drive_req(1, 32'hBEEF_0000, 16'h20, 1'b0);
        push_issue(1, 32'hBEEF_0000, 16'h20, 1'b0, 1'b0);
        tick();
        req_start = '0;
        starts = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_start) starts++;
            tick();
        end
        chk("busy_start_cycles", 64'(starts), 64'd6);
        wait_drain("busy_drain", 100);
        chk("busy_start_after", 64'(mem_start), 64'd0);

        // Lock: port 1 chains while port 0 waits.
        drive_req(1, 32'h2000_0000, 16'h10, 1'b1);
        push_issue(1, 32'h2000_0000, 16'h10, 1'b1, 1'b0);
        tick();
        req_start = '0;
        drive_req(0, 32'h3000_0000, 16'h30, 1'b0);
        tick();
        req_start = '0;
        wait_drain("lock_first_drain", 100);
        for (int c = 0; c < 15; c++) begin
            chk("lock_hold_start", 64'(mem_start), 64'd0);
            chk("lock_hold_busy", 64'(req_busy), 64'b01);
            tick();
        end
        drive_req(1, 32'h2000_0100, 16'h10, 1'b0);
        push_issue(1, 32'h2000_0100, 16'h10, 1'b0, 1'b0);
        push_issue(0, 32'h3000_0000, 16'h30, 1'b0, 1'b0);
        tick();
        req_start = '0;
        wait_drain("lock_release_drain", 200);

        // Error on a chained transfer drops the lock.
        drive_req(1, 32'h4000_0000, 16'd8, 1'b1);
        push_issue(1, 32'h4000_0000, 16'd8, 1'b1, 1'b1);
        tick();
        req_start = '0;
        drive_req(0, 32'h5000_0000, 16'd8, 1'b0);
        push_issue(0, 32'h5000_0000, 16'd8, 1'b0, 1'b0);
        tick();
        req_start = '0;
        wait_drain("err_lock_drain", 200);

        // Reset while waiting for the engine; the late done must be ignored.
        drive_req(1, 32'h6000_0000, 16'h40, 1'b0);
        push_issue(1, 32'h6000_0000, 16'h40, 1'b0, 1'b0);
        tick();
        req_start = '0;
        begin
            int n = 0;
            while (exp_issue.size() != 0 && n < 20) begin
                tick();
                n++;
            end
            chk("rstw_accept", 64'(n < 20), 64'd1);
        end
        tick();
        eng_drop = 1'b1;
        reset_dut();
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("rstw_busy", 64'(req_busy), 64'd0);
            chk("rstw_done", 64'(req_done), 64'd0);
            chk("rstw_start", 64'(mem_start), 64'd0);
        end
        chk("rstw_engine_idle", 64'(eng_cnt), 64'd0);
        eng_drop = 1'b0;
        push_issue(0, 32'h7000_0000, 16'h11, 1'b0, 1'b0);
        push_issue(1, 32'h7100_0000, 16'h22, 1'b0, 1'b0);
        drive_req(0, 32'h7000_0000, 16'h11, 1'b0);
        drive_req(1, 32'h7100_0000, 16'h22, 1'b0);
        tick();
        req_start = '0;
        wait_drain("rstw_after_drain", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
